simon_input_ctrl: RTL and testbench

- Sits directly downstream of the PS/2 receiver. Consumes its one-cycle `btn_pulse` / `btn_code[7:0]` (scan code of a released key) and maps scan codes to the four game colours.
- Checks the player's key entries against the stored Simon sequence for one round, with a per-key inactivity timeout.
- Reports round pass/fail to the game FSM and echoes each accepted key for LED feedback.

---
 rtl/simon_input_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_simon_input_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_input_ctrl.sv
// Purpose : maps PS/2 release codes to Simon colours and checks one round of
//           player entries against the stored sequence, with per-key timeout.
// Latency : 1 cycle, every output is registered; no backpressure (btn_pulse
//           and start are one-cycle strobes that are consumed or ignored).
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   btn_pulse/code    one-cycle strobe + scan code from the PS/2 receiver
//   start/round_len   begin checking a round of round_len keys (IDLE only)
//   seq_color/seq_idx combinational sequence-memory read port
//   busy              round in progress
//   key_valid/color   echo of every mapped key (LED feedback)
//   round_pass/fail   one-cycle result strobes
//   fail_timeout      last failure was a timeout (cleared by accepted start)
module simon_input_ctrl #(
  parameter int unsigned IDX_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 250000000,
  parameter logic [7:0]  CODE_C0        = 8'h1D,
  parameter logic [7:0]  CODE_C1        = 8'h1C,
  parameter logic [7:0]  CODE_C2        = 8'h1B,
  parameter logic [7:0]  CODE_C3        = 8'h23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_pulse,
  input  logic [7:0]       btn_code,
  input  logic             start,
  input  logic [IDX_W:0]   round_len,
  input  logic [1:0]       seq_color,
  output logic [IDX_W-1:0] seq_idx,
  output logic             busy,
  output logic             key_valid,
  output logic [1:0]       key_color,
  output logic             round_pass,
  output logic             round_fail,
  output logic             fail_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W:0] LEN_ONE = (IDX_W + 1)'(1);
  // Longest round the index can address: 2**IDX_W keys.
  localparam logic [IDX_W:0] LEN_MAX = {1'b1, {IDX_W{1'b0}}};

  typedef enum logic {
    IDLE,
    WAIT_KEY
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   len_q, len_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             busy_q, busy_d;
  logic             kv_q, kv_d;
  logic [1:0]       kc_q, kc_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             fto_q, fto_d;

  // Scan-code decode. Unmapped codes produce no strobe at all, so they are
  // invisible to the round logic (in particular they do not restart the timer).
  logic       key_mapped;
  logic [1:0] key_col;

  always_comb begin
    key_mapped = 1'b0;
    key_col    = 2'd0;
    if (btn_pulse) begin
      if (btn_code == CODE_C0) begin
        key_mapped = 1'b1;
        key_col    = 2'd0;
      end else if (btn_code == CODE_C1) begin
        key_mapped = 1'b1;
        key_col    = 2'd1;
      end else if (btn_code == CODE_C2) begin
        key_mapped = 1'b1;
        key_col    = 2'd2;
      end else if (btn_code == CODE_C3) begin
        key_mapped = 1'b1;
        key_col    = 2'd3;
      end
    end
  end

  logic key_last;
  assign key_last = ({1'b0, idx_q} == (len_q - LEN_ONE));

  // Next-state / output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    timer_d = timer_q;
    busy_d  = busy_q;
    kv_d    = 1'b0;
    kc_d    = kc_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    fto_d   = fto_q;

    // Key echo is independent of the round state.
    if (key_mapped) begin
      kv_d = 1'b1;
      kc_d = key_col;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          timer_d = '0;
          fto_d   = 1'b0;
          if (round_len == '0) begin
            // Empty round passes immediately without ever going busy.
            len_d  = '0;
            pass_d = 1'b1;
          end else begin
            len_d   = (round_len > LEN_MAX) ? LEN_MAX : round_len;
            busy_d  = 1'b1;
            state_d = WAIT_KEY;
          end
        end
      end

      WAIT_KEY: begin
        // A key arriving on the timeout cycle takes priority over the timeout.
        if (key_mapped) begin
          if (key_col == seq_color) begin
            if (key_last) begin
              pass_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              idx_d   = idx_q + IDX_ONE;
              timer_d = '0;
            end
          end else begin
            fail_d  = 1'b1;
            fto_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (timer_q == TIMER_LAST) begin
          fail_d  = 1'b1;
          fto_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      kv_q    <= 1'b0;
      kc_q    <= 2'd0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      fto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      kv_q    <= kv_d;
      kc_q    <= kc_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      fto_q   <= fto_d;
    end
  end

  assign seq_idx      = idx_q;
  assign busy         = busy_q;
  assign key_valid    = kv_q;
  assign key_color    = kc_q;
  assign round_pass   = pass_q;
  assign round_fail   = fail_q;
  assign fail_timeout = fto_q;

endmodule

// File: tb/tb_simon_input_ctrl.sv
// Purpose : randomized + directed bench for simon_input_ctrl against a
//           cycle-level behavioural model of the round rules.
// Latency : outputs compared 1 ns after each rising edge.
module tb_simon_input_ctrl;

  localparam int T     = 20;
  localparam int IDX_W = 5;
  localparam int MAXL  = 32;

  logic             clk;
  logic             rst;
  logic             btn_pulse;
  logic [7:0]       btn_code;
  logic             start;
  logic [IDX_W:0]   round_len;
  logic [1:0]       seq_color;
  logic [IDX_W-1:0] seq_idx;
  logic             busy;
  logic             key_valid;
  logic [1:0]       key_color;
  logic             round_pass;
  logic             round_fail;
  logic             fail_timeout;

  logic [1:0] mem [MAXL];
  logic [7:0] codes [4];

  int n_tests;
  int n_fail;

  // Reference model state
  bit e_busy;
  int e_idx;
  int e_len;
  int e_since;
  bit e_kv;
  int e_kc;
  bit e_pass;
  bit e_fail;
  bit e_fto;

  simon_input_ctrl #(
    .IDX_W(IDX_W),
    .TIMEOUT_CYCLES(T),
    .CODE_C0(8'h1D),
    .CODE_C1(8'h1C),
    .CODE_C2(8'h1B),
    .CODE_C3(8'h23)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_pulse(btn_pulse),
    .btn_code(btn_code),
    .start(start),
    .round_len(round_len),
    .seq_color(seq_color),
    .seq_idx(seq_idx),
    .busy(busy),
    .key_valid(key_valid),
    .key_color(key_color),
    .round_pass(round_pass),
    .round_fail(round_fail),
    .fail_timeout(fail_timeout)
  );

  // Sequence memory read port
  assign seq_color = mem[seq_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_busy = 0; e_idx = 0; e_len = 0; e_since = 0;
    e_kv = 0; e_kc = 0; e_pass = 0; e_fail = 0; e_fto = 0;
  endtask

  // One clock edge of the round rules, using the inputs present before it.
  task automatic model_update();
    bit mapped;
    int col;
    mapped = 0;
    col    = 0;
    if (btn_pulse)
      for (int i = 0; i < 4; i++)
        if (btn_code == codes[i]) begin
          mapped = 1;
          col    = i;
        end
    e_kv   = mapped;
    if (mapped) e_kc = col;
    e_pass = 0;
    e_fail = 0;
    if (!e_busy) begin
      if (start) begin
        e_idx   = 0;
        e_fto   = 0;
        e_since = 0;
        if (round_len == 0) e_pass = 1;
        else begin
          e_busy = 1;
          e_len  = (int'(round_len) > MAXL) ? MAXL : int'(round_len);
        end
      end
    end else if (mapped) begin
      if (col == int'(mem[e_idx])) begin
        if (e_idx == e_len - 1) begin
          e_pass = 1;
          e_busy = 0;
        end else begin
          e_idx++;
          e_since = 0;
        end
      end else begin
        e_fail = 1;
        e_fto  = 0;
        e_busy = 0;
      end
    end else begin
      e_since++;
      if (e_since == T) begin
        e_fail = 1;
        e_fto  = 1;
        e_busy = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("busy", busy, e_busy);
    chk("seq_idx", seq_idx, e_idx);
    chk("key_valid", key_valid, e_kv);
    chk("key_color", key_color, e_kc);
    chk("round_pass", round_pass, e_pass);
    chk("round_fail", round_fail, e_fail);
    chk("fail_timeout", fail_timeout, e_fto);
    chk("pass_fail_excl", round_pass & round_fail, 0);
  endtask

  task automatic step(input bit p, input logic [7:0] c, input bit s, input logic [IDX_W:0] l);
    btn_pulse = p;
    btn_code  = c;
    start     = s;
    round_len = l;
    @(posedge clk);
    model_update();
    #1;
    check_all();
    btn_pulse = 0;
    btn_code  = 8'h00;
    start     = 0;
    round_len = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, '0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_idx"}, seq_idx, 0);
    chk({tag, "_kv"}, key_valid, 0);
    chk({tag, "_kc"}, key_color, 0);
    chk({tag, "_pass"}, round_pass, 0);
    chk({tag, "_fail"}, round_fail, 0);
    chk({tag, "_fto"}, fail_timeout, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    codes[0] = 8'h1D; codes[1] = 8'h1C; codes[2] = 8'h1B; codes[3] = 8'h23;
    for (int i = 0; i < MAXL; i++) mem[i] = 2'd0;
    rst = 1'b0;
    btn_pulse = 0; btn_code = 8'h00; start = 0; round_len = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;

    // Mapped key in IDLE: echo only
    step(1, 8'h1C, 0, '0);
    chk("idle_kv", key_valid, 1);
    chk("idle_kc", key_color, 1);
    chk("idle_busy", busy, 0);
    idle(1);
    chk("idle_kv_off", key_valid, 0);
    chk("idle_kc_hold", key_color, 1);

    // Round of 3 keys, all correct
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    step(0, 8'h00, 1, 6'd3);
    chk("r3_busy", busy, 1);
    step(1, 8'h1B, 0, '0);
    chk("r3_idx1", seq_idx, 1);
    step(1, 8'h1D, 0, '0);
    chk("r3_idx2", seq_idx, 2);
    step(1, 8'h23, 0, '0);
    chk("r3_pass", round_pass, 1);
    chk("r3_busy_end", busy, 0);
    idle(1);

    // Wrong second key
    mem[0] = 2'd1; mem[1] = 2'd1;
    step(0, 8'h00, 1, 6'd2);
    step(1, 8'h1C, 0, '0);
    step(1, 8'h1D, 0, '0);
    chk("wrong_fail", round_fail, 1);
    chk("wrong_fto", fail_timeout, 0);
    chk("wrong_idx", seq_idx, 1);
    idle(1);

    // Timeout with no keys: fail exactly T cycles after start
    step(0, 8'h00, 1, 6'd4);
    for (int k = 1; k < T; k++) begin
      step(0, 8'h00, 0, '0);
      chk("to_early", round_fail, 0);
    end
    step(0, 8'h00, 0, '0);
    chk("to_fail", round_fail, 1);
    chk("to_fto", fail_timeout, 1);
    mem[0] = 2'd2;
    step(0, 8'h00, 1, 6'd1);
    chk("to_fto_clr", fail_timeout, 0);
    step(1, 8'h1B, 0, '0);
    chk("len1_pass", round_pass, 1);

    // Unmapped code does not restart the timer
    step(0, 8'h00, 1, 6'd4);
    for (int k = 1; k <= T; k++) begin
      if (k == 10) begin
        step(1, 8'h5A, 0, '0);
        chk("unmapped_kv", key_valid, 0);
      end else step(0, 8'h00, 0, '0);
    end
    chk("unmapped_to", round_fail, 1);

    // Matching key on the timeout cycle wins
    mem[0] = 2'd0;
    step(0, 8'h00, 1, 6'd4);
    idle(T - 1);
    step(1, 8'h1D, 0, '0);
    chk("edge_nofail", round_fail, 0);
    chk("edge_idx", seq_idx, 1);
    // start during a round is ignored
    step(0, 8'h00, 1, 6'd0);
    chk("ign_pass", round_pass, 0);
    chk("ign_busy", busy, 1);

    // Asynchronous reset mid-round
    rst = 1'b0;
    #2;
    chk_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_all();

    // Zero-length round
    step(0, 8'h00, 1, 6'd0);
    chk("len0_pass", round_pass, 1);
    chk("len0_busy", busy, 0);
    idle(1);

    // Length above 2**IDX_W clamps to 32 keys
    for (int i = 0; i < MAXL; i++) mem[i] = 2'($urandom_range(0, 3));
    step(0, 8'h00, 1, 6'd40);
    for (int i = 0; i < MAXL; i++) step(1, codes[mem[i]], 0, '0);
    chk("clamp_pass", round_pass, 1);
    idle(2);

    // Randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit p, s;
      logic [7:0] c;
      logic [IDX_W:0] l;
      int r;
      p = ($urandom_range(0, 5) == 0);
      c = 8'h00;
      if (p) begin
        r = $urandom_range(0, 9);
        if (e_busy && r < 8) c = codes[mem[e_idx]];
        else if (r < 8) c = codes[$urandom_range(0, 3)];
        else if (r == 8) c = 8'h5A;
        else c = 8'($urandom_range(0, 255));
      end
      s = ($urandom_range(0, 15) == 0);
      if (e_busy) l = (IDX_W + 1)'($urandom_range(0, 40));
      else begin
        l = ($urandom_range(0, 3) == 0) ? (IDX_W + 1)'($urandom_range(1, 40))
                                        : (IDX_W + 1)'($urandom_range(1, 4));
        if (s) for (int i = 0; i < MAXL; i++) mem[i] = 2'($urandom_range(0, 3));
      end
      step(p, c, s, l);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
